if_id_register: RTL
===================

Name: if_id_register

Overview:
- Pipeline register between instruction fetch (program counter plus instruction memory) and decode in the 5-stage MIPS32 core.
- Captures the fetched instruction word and its PC, and precomputes PC+4 and PC+8 (PC+8 is the link address for jal/jalr/bgezal with a delay slot).
- Flags instruction-fetch address errors (AdEL) and substitutes a NOP.
- Honours stall and flush from the hazard/exception unit; keeps saturating stall and bubble counters for debug.

Parameters:
- RESET_PC, 32'h00003000, PC value presented in decode after reset.
- IMEM_BASE, 32'h00003000, lowest legal fetch address.
- IMEM_SIZE, 32'h00001000, legal fetch window size in bytes (4 KiB).
- CNT_W, 16, width of the debug counters.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- instr_F  in  32  instruction word read from instruction memory at PC_F.
- PC_F  in  32  current fetch address (program counter output).
- stall  in  1  hold decode contents; the hazard unit drives the program counter enable with ~stall.
- flush  in  1  replace decode contents with a bubble (exception/eret redirect).
- instr_D  out  32  instruction in decode.
- PC_D  out  32  its address.
- PC4_D  out  32  PC_D + 4.
- PC8_D  out  32  PC_D + 8.
- valid_D  out  1  decode holds a real (non-bubble) instruction.
- adel_D  out  1  fetch address error for the instruction in decode.
- stall_cnt  out  CNT_W  cycles in which stall held the register.
- bubble_cnt  out  CNT_W  cycles in which a bubble was inserted by flush.

Behaviour:
- All state updates on the rising edge of clk only; outputs are registered, with no combinational input-to-output path.
- Update priority, highest first: reset > flush > stall > load.
- reset: instr_D=0, PC_D=RESET_PC, PC4_D=RESET_PC+4, PC8_D=RESET_PC+8, valid_D=0, adel_D=0, stall_cnt=0, bubble_cnt=0. Reset mid-stall or mid-flush still applies these exact values.
- flush (no reset): instr_D=32'h0 (sll $0,$0,0 = NOP), valid_D=0, adel_D=0. PC_D/PC4_D/PC8_D hold. bubble_cnt+1.
- flush and stall together: flush wins, stall_cnt is not incremented.
- stall (no reset, no flush): every data output holds. stall_cnt+1.
- load (none of the above): PC_D=PC_F, PC4_D=PC_F+4, PC8_D=PC_F+8, valid_D=1.
  - Fetch address legal: instr_D=instr_F, adel_D=0.
  - Fetch address error: instr_D=0, adel_D=1.
- Fetch address error condition: PC_F[1:0]!=0, OR PC_F<IMEM_BASE, OR PC_F>=IMEM_BASE+IMEM_SIZE. Compare as unsigned 33-bit so IMEM_BASE+IMEM_SIZE cannot overflow.
- Arithmetic: PC4/PC8 are modulo 2^32. PC_F=32'hFFFFFFFC gives PC4_D=0 and PC8_D=4 (adel_D still set if out of window).
- Counters saturate at all-ones and do not wrap; they are cleared only by reset.
- Latency: 1 cycle from PC_F/instr_F to decode outputs when not stalled.

Decomposition:
- Shared package (mips_defs): NOP_INSTR=32'h0, RESET_PC=32'h00003000, IMEM_BASE/IMEM_SIZE defaults. The program counter and this block both reference RESET_PC from there.
- One combinational sub-module, fetch_addr_check (PC in, adel out; parameters IMEM_BASE/IMEM_SIZE). It is reused later by the data-memory AdEL/AdES logic.
- Counters stay inline.

Test Plan:
- Reset, then load with reset=1 held 2 cycles -> PC_D=0x3000, PC4_D=0x3004, PC8_D=0x3008, instr_D=0, valid_D=0, counters 0. Next cycle after release with PC_F=0x3000, instr_F=0x3C010001 -> instr_D=0x3C010001, valid_D=1, PC8_D=0x3008.
- Stall for 3 cycles while PC_F/instr_F change -> all data outputs hold the pre-stall values, stall_cnt=3. Release -> the new PC_F is loaded.
- flush=1 and stall=1 in the same cycle with instr_D=0x8C220004 -> instr_D=0, valid_D=0, PC_D unchanged, bubble_cnt=1, stall_cnt unchanged.
- Fetch window edges:
  - PC_F=0x3FFC -> adel_D=0.
  - PC_F=0x4000 -> adel_D=1, instr_D=0, valid_D=1.
  - PC_F=0x2FFC -> adel_D=1.
  - PC_F=0x3002 -> adel_D=1.
- PC wrap: PC_F=0xFFFFFFFC -> PC4_D=0x0, PC8_D=0x4, adel_D=1.
- Counter saturation: with CNT_W=4, stall for 20 cycles -> stall_cnt=15 and holds. Then assert reset mid-stall -> stall_cnt=0 and PC_D=0x3000.

Source files
------------

// File: rtl/if_id_register_pkg.sv
// Shared MIPS32 core definitions: reset vector, instruction-memory window,
// and the IF/ID pipeline record used by the fetch/decode boundary.
package mips_defs;

   localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;  // sll $0,$0,0
   localparam logic [31:0] RESET_PC      = 32'h0000_3000;
   localparam logic [31:0] IMEM_BASE     = 32'h0000_3000;
   localparam logic [31:0] IMEM_SIZE     = 32'h0000_1000;
   localparam int          CNT_W_DEFAULT = 16;

   // Contents of the decode stage as seen by everything downstream.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] pc8;
      logic        valid;
      logic        adel;
   } if_id_t;

   // How the register is updated this cycle when reset is not asserted.
   typedef enum logic [1:0] {
      UPD_LOAD  = 2'd0,
      UPD_STALL = 2'd1,
      UPD_FLUSH = 2'd2
   } upd_e;

   // Decode-stage record for a given PC; PC+4/PC+8 wrap modulo 2^32.
   function automatic if_id_t make_stage(input logic [31:0] instr,
                                         input logic [31:0] pc,
                                         input logic        valid,
                                         input logic        adel);
      if_id_t s;
      s.instr = instr;
      s.pc    = pc;
      s.pc4   = pc + 32'd4;
      s.pc8   = pc + 32'd8;
      s.valid = valid;
      s.adel  = adel;
      return s;
   endfunction

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational address-error check: misaligned or outside [BASE, BASE+SIZE).
// Bounds are compared as 33-bit unsigned so BASE+SIZE never overflows.
module fetch_addr_check #(
   parameter logic [31:0] IMEM_BASE  = mips_defs::IMEM_BASE,
   parameter logic [31:0] IMEM_SIZE  = mips_defs::IMEM_SIZE,
   parameter logic [1:0]  ALIGN_MASK = 2'b11
) (
   input  logic [31:0] addr,
   output logic        adel
);

   localparam logic [32:0] LO_BOUND = {1'b0, IMEM_BASE};
   localparam logic [32:0] HI_BOUND = {1'b0, IMEM_BASE} + {1'b0, IMEM_SIZE};

   logic [32:0] addr_ext;
   logic        misaligned;
   logic        below;
   logic        above;

   always_comb begin
      addr_ext   = {1'b0, addr};
      misaligned = (addr[1:0] & ALIGN_MASK) != 2'b00;
      below      = addr_ext < LO_BOUND;
      above      = addr_ext >= HI_BOUND;
      adel       = misaligned | below | above;
   end

endmodule

// File: rtl/if_id_register.sv
// IF/ID pipeline register of the 5-stage MIPS32 core: captures instruction
// and PC, precomputes PC+4/PC+8, flags fetch AdEL, and keeps debug counters.
module if_id_register #(
   parameter logic [31:0] RESET_PC  = mips_defs::RESET_PC,
   parameter logic [31:0] IMEM_BASE = mips_defs::IMEM_BASE,
   parameter logic [31:0] IMEM_SIZE = mips_defs::IMEM_SIZE,
   parameter int          CNT_W     = mips_defs::CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instr_F,
   input  logic [31:0]      PC_F,
   input  logic             stall,
   input  logic             flush,
   output logic [31:0]      instr_D,
   output logic [31:0]      PC_D,
   output logic [31:0]      PC4_D,
   output logic [31:0]      PC8_D,
   output logic             valid_D,
   output logic             adel_D,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);

   import mips_defs::*;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam if_id_t RESET_STAGE = '{
      instr: NOP_INSTR,
      pc:    RESET_PC,
      pc4:   RESET_PC + 32'd4,
      pc8:   RESET_PC + 32'd8,
      valid: 1'b0,
      adel:  1'b0
   };

   if_id_t           stage_q, stage_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
   upd_e             upd;
   logic             fetch_adel;

   fetch_addr_check #(
      .IMEM_BASE  (IMEM_BASE),
      .IMEM_SIZE  (IMEM_SIZE),
      .ALIGN_MASK (2'b11)
   ) u_fetch_addr_check (
      .addr (PC_F),
      .adel (fetch_adel)
   );

   // Flush outranks stall so a redirect is never lost behind a hazard hold.
   always_comb begin
      if (flush) begin
         upd = UPD_FLUSH;
      end else if (stall) begin
         upd = UPD_STALL;
      end else begin
         upd = UPD_LOAD;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      stage_d      = stage_q;
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      unique case (upd)
         UPD_FLUSH: begin
            stage_d.instr = NOP_INSTR;
            stage_d.valid = 1'b0;
            stage_d.adel  = 1'b0;
            if (bubble_cnt_q != CNT_MAX) begin
               bubble_cnt_d = bubble_cnt_q + CNT_ONE;
            end
         end
         UPD_STALL: begin
            if (stall_cnt_q != CNT_MAX) begin
               stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
         end
         UPD_LOAD: begin
            stage_d = make_stage(fetch_adel ? NOP_INSTR : instr_F,
                                 PC_F, 1'b1, fetch_adel);
         end
         default: begin
            stage_d = stage_q;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its pre-edge value regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q      <= RESET_STAGE;
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stage_q      <= stage_d;
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   always_comb begin
      instr_D    = stage_q.instr;
      PC_D       = stage_q.pc;
      PC4_D      = stage_q.pc4;
      PC8_D      = stage_q.pc8;
      valid_D    = stage_q.valid;
      adel_D     = stage_q.adel;
      stall_cnt  = stall_cnt_q;
      bubble_cnt = bubble_cnt_q;
   end

endmodule
